// File: rtl/seq_pkg.sv
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and constants for the sequence-detector front end
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int          c_DEFAULT_WIDTH = 8;
    localparam logic [4:0]  c_DET_PATTERN   = 5'b10110;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_hold_reg.sv
// ============================================================================
//  Module      : serializer_hold_reg
//  Description : Single-entry holding register with full flag and ready output
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializer_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_hold_data,
    output logic              o_hold_full,
    output logic              o_load_ready
);

    logic [DATA_W-1:0] r_hold;
    logic              r_full;

    // Writes only happen while empty and reads only while full, so they never collide
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (i_wr_en) begin
            r_hold <= i_wr_data;
            r_full <= 1'b1;
        end else if (i_rd_en) begin
            r_full <= 1'b0;
        end
    end

    assign o_hold_data  = r_hold;
    assign o_hold_full  = r_full;
    assign o_load_ready = rst & ~r_full;

endmodule

`default_nettype wire

// File: rtl/seq_stream_serializer.sv
// ============================================================================
//  Module      : seq_stream_serializer
//  Description : Parallel-to-serial feeder with one-word hold buffer and stall.
//                Optional even-parity trailer bit when PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_stream_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             adv,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);

`ifdef PARITY_EN
    localparam int c_FRAME_W = WIDTH + 1;
`else
    localparam int c_FRAME_W = WIDTH;
`endif
    localparam int                 c_CNT_W    = clog2(WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_FRAME_W);

    state_t               r_state;
    logic [c_FRAME_W-1:0] r_sh;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_frame_done;

    logic [c_FRAME_W-1:0] w_load_frame;
    logic [c_FRAME_W-1:0] w_hold_frame;
    logic [c_FRAME_W-1:0] w_shifted;
    logic                 w_hold_full;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_bypass;
    logic                 w_hold_wr;
    logic                 w_hold_rd;

    // Parity sits at the far end of the frame so it leaves after the data bits
`ifdef PARITY_EN
    assign w_load_frame = MSB_FIRST ? {load_data, ^load_data} : {^load_data, load_data};
`else
    assign w_load_frame = load_data;
`endif

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_sh[c_FRAME_W-2:0], 1'b0};
            assign sout      = r_sh[c_FRAME_W-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_sh[c_FRAME_W-1:1]};
            assign sout      = r_sh[0];
        end
    endgenerate

    assign w_accept  = load_valid & load_ready;
    assign w_last    = (r_state == SHIFT) & adv & (r_cnt == c_CNT_W'(1));
    assign w_bypass  = w_last & ~w_hold_full & w_accept;
    assign w_hold_wr = (r_state == SHIFT) & w_accept & ~w_bypass;
    assign w_hold_rd = w_last & w_hold_full;

    serializer_hold_reg #(
        .DATA_W (c_FRAME_W)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .i_wr_data    (w_load_frame),
        .i_wr_en      (w_hold_wr),
        .i_rd_en      (w_hold_rd),
        .o_hold_data  (w_hold_frame),
        .o_hold_full  (w_hold_full),
        .o_load_ready (load_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sh    <= w_load_frame;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (adv) begin
                        if (r_cnt == c_CNT_W'(1)) begin
                            r_frame_done <= 1'b1;
                            if (w_hold_full) begin
                                r_sh  <= w_hold_frame;
                                r_cnt <= c_CNT_LOAD;
                            end else if (w_accept) begin
                                r_sh  <= w_load_frame;
                                r_cnt <= c_CNT_LOAD;
                            end else begin
                                r_sh    <= '0;
                                r_cnt   <= '0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_sh  <= w_shifted;
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign sout_valid = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT) | w_hold_full;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: doc/seq_stream_serializer.md
Name: seq_stream_serializer

Overview:
Parallel-to-serial front end that feeds the sequence-detector stage's `din` one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out MSB- or LSB-first on `sout`, with per-bit `sout_valid`.
- A one-word holding register allows back-to-back words with no bubble bit.
- `adv` lets the consumer stall the bit stream.

Parameters:
WIDTH, 8, data word width in bits (≥2)
MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge)
load_data  in  WIDTH  word to serialize
load_valid  in  1  load_data valid
load_ready  out  1  block can accept a word (= !hold_full; forced 0 while rst=0)
adv  in  1  consumer takes the current bit this cycle (tie 1 for free-running feed)
sout  out  1  current serial bit (feeds detector din)
sout_valid  out  1  sout carries a data bit
busy  out  1  state==SHIFT or hold_full
frame_done  out  1  one-cycle pulse, registered, after the last bit of a word is consumed

Behaviour:
- Storage:
  - Shift register `sh[WIDTH-1:0]`.
  - Bit counter `cnt`, width clog2(WIDTH+2).
  - Holding register `hold[WIDTH-1:0]` with flag `hold_full`.
  - FSM with 2 states: IDLE, SHIFT.
- Reset (rst=0 at a clk edge):
  - state=IDLE, sh=0, cnt=0, hold=0, hold_full=0, frame_done=0.
  - Outputs: sout=0, sout_valid=0, busy=0, load_ready=0 during reset, 1 on the first cycle after release.
  - Reset mid-word discards all in-flight bits; no frame_done is produced for the discarded word.
- Accept = load_valid & load_ready at a clk edge.
- sout = sh[WIDTH-1] if MSB_FIRST, else sh[0]. sout_valid = (state==SHIFT). Both derive from registers only; no combinational path from inputs.
- IDLE:
  - On accept: sh<=load_data, cnt<=WIDTH, go to SHIFT.
  - Latency: word accepted at edge N gives its first bit valid in the cycle after edge N.
- SHIFT, adv=0: sh, cnt and sout hold (stall).
- SHIFT, adv=1, cnt>1: shift sh by 1 toward the output end, zero-fill, cnt--.
- SHIFT, adv=1, cnt==1 (last bit consumed): frame_done<=1 next cycle, then:
  - hold_full=1: sh<=hold, hold_full<=0, cnt<=WIDTH, stay in SHIFT (no bubble).
  - hold_full=0 and accept this same cycle: bypass, so sh<=load_data, cnt<=WIDTH, stay in SHIFT.
  - Otherwise: go to IDLE, sh<=0.
- SHIFT, accept while not taking the last-bit bypass path: hold<=load_data, hold_full<=1.
- Hold register full: load_ready=0 and no further words are accepted. hold_full never overflows.
- Simultaneous hold unload and incoming load_valid: the word is not accepted (load_ready was 0); load_ready rises the next cycle.
- adv is ignored in IDLE. adv=0 on the last bit delays frame_done until adv=1.

Optional Feature:
PARITY_EN
- Defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of the word) is shifted out with sout_valid=1, and cnt loads WIDTH+1.
  - frame_done pulses after the parity bit is consumed.
  - The parity bit is computed at load time and stored alongside sh/hold.
- Undefined: no parity bit and no extra storage; behaviour exactly as above.

Decomposition:
- Shared package `seq_pkg`:
  - FSM state encoding typedef: IDLE=1'b0, SHIFT=1'b1.
  - Default WIDTH constant.
  - Counter-width function clog2.
  - The 10110 pattern constant shared with the detector stage.
- One natural sub-module, `serializer_hold_reg`: the single-entry holding register with its hold_full flag and load_ready generation. The shift datapath and FSM stay in the top.

Test Plan:
1. Reset then single word: rst=0 for 2 cycles, then WIDTH=8, MSB_FIRST=1, load 8'hB0 with adv=1 → sout 1,0,1,1,0,0,0,0 on 8 consecutive cycles starting the cycle after accept. frame_done pulses once, then IDLE with sout_valid=0.
2. Back-to-back: load 8'hB0 then 8'h5A immediately (second word lands in hold) → 16 contiguous valid bits, no gap. load_ready=0 from the accept of 8'h5A until the hold register unloads. Two frame_done pulses, 8 cycles apart.
3. Stall: assert adv=0 for 3 cycles after the 3rd bit of 8'hB0 → sout holds 1 for those cycles, total 11 cycles of sout_valid, bit order unchanged.
4. Bypass: with hold empty, present 8'hFF on exactly the last-bit cycle of a word → no IDLE cycle, next bit 1 immediately after. Same input with hold full → not accepted, load_ready=0 that cycle.
5. Mid-word reset: rst=0 after bit 4 of 8'hB0 → next cycle sout_valid=0, busy=0, no frame_done. A word loaded after reset serializes correctly.
6. PARITY_EN defined, MSB_FIRST=0, load 8'h07 → sout 1,1,1,0,0,0,0,0 then parity 1. frame_done after the 9th bit.
